regfile_access_arbiter: RTL and testbench
=========================================

Name: regfile_access_arbiter

Overview:
- Shares the single write port and read port A of the 2^AWIDTH x DWIDTH register file between two requesters (R0, R1).
- Fair round-robin arbitration, valid/ready command handshake, one command granted per cycle.
- Read data is returned one cycle after grant, matching the file's registered read.
- After reset, an optional init sequence clears every register to zero before any requester is served.

Parameters:
- DWIDTH, 32, data width of register-file entries
- AWIDTH, 5, register address width; file depth = 2^AWIDTH
- INIT_EN, 1, 1 = run the zero-clear sequence after reset; 0 = go straight to service

Ports:
- CLK  in  1  clock; all state updates on posedge
- RST  in  1  reset, synchronous, active-high
- REQ_VALID_0 / REQ_VALID_1  in  1  requester command valid
- REQ_READY_0 / REQ_READY_1  out  1  command accepted (grant) this cycle
- REQ_WR_0 / REQ_WR_1  in  1  1 = write, 0 = read
- REQ_ADDR_0 / REQ_ADDR_1  in  AWIDTH  register address
- REQ_WDATA_0 / REQ_WDATA_1  in  DWIDTH  write data
- RVALID_0 / RVALID_1  out  1  read data valid, one-cycle pulse
- RDATA_0 / RDATA_1  out  DWIDTH  read data
- BUSY  out  1  init sequence in progress
- RF_WE  out  1  to file: write enable
- RF_WA  out  AWIDTH  to file: write address
- RF_DATAIN  out  DWIDTH  to file: write data
- RF_RE_A  out  1  to file: read enable port A
- RF_RA_A  out  AWIDTH  to file: read address port A
- RF_OUT_A  in  DWIDTH  from file: port A data, registered inside the file

Behaviour:
- Clock and reset: single clock CLK. RST is synchronous, active-high; it is sampled only on posedge CLK.
- While RST is high:
  - REQ_READY_x=0, RVALID_x=0, RF_WE=0, RF_RE_A=0, BUSY=0.
  - Init counter cleared to 0; round-robin pointer set to "R1 last granted", so R0 wins the first tie.
- State machine: RESET -> INIT (INIT_EN=1) or RUN (INIT_EN=0) on the first cycle after RST falls.
  - INIT:
    - BUSY=1, both REQ_READY=0.
    - Drives RF_WE=1, RF_WA=cnt, RF_DATAIN=0; cnt increments each cycle.
    - After cnt = 2^AWIDTH-1 is written, moves to RUN; exactly 2^AWIDTH cycles.
  - RUN:
    - BUSY=0; arbitration active. No return to INIT except via RST.
- Arbitration in RUN, combinational within the cycle:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester that did not receive the most recent grant.
  - Pointer updates only on an actual grant; idle cycles leave it unchanged.
  - REQ_READY_x=1 only for the granted requester. The command transfers when VALID && READY.
  - Requester holds its command stable until READY.
- Grant of a write:
  - RF_WE=1, RF_WA=ADDR, RF_DATAIN=WDATA in the same cycle.
  - File updates at that edge; no response to the requester.
- Grant of a read:
  - RF_RE_A=1, RF_RA_A=ADDR in the grant cycle.
  - Next cycle: RVALID_x=1 for the granted requester, RDATA_x=RF_OUT_A.
  - Latency is grant cycle + 1.
- RF_WE and RF_RE_A are never both 1 in the same cycle.
- When not enabled, RF_WA, RF_RA_A and RF_DATAIN are driven 0. RDATA_x is driven 0 when RVALID_x=0.
- Read-after-write: a read granted in the cycle after a write to the same address returns the new data, because the write committed at the prior edge. Grants are serialized, so no bypass is needed.
- Back-to-back reads, the same or alternating requester, are sustained at one per cycle.
- Reset mid-operation:
  - A pending RVALID is suppressed. The next cycle shows RVALID=0.
  - In-progress INIT restarts from cnt=0 after RST falls.
- Requests asserted during INIT are held off; no READY until RUN.

Test Plan:
- Init: RST high 2 cycles then low, INIT_EN=1, AWIDTH=5 -> BUSY=1 for exactly 32 cycles, RF_WE=1 with RF_WA 0..31 and RF_DATAIN=0; then R0 read of addr 7 -> RDATA_0=0.
- Write then read: R0 writes 0xDEADBEEF to addr 3; next cycle R0 reads addr 3 -> READY_0 each cycle, RVALID_0 one cycle after the read grant, RDATA_0=0xDEADBEEF.
- Contention: R0 and R1 both hold reads of addr 1 and 2 (preloaded 0x11, 0x22) -> grants R0, R1 alternate; RVALID_0 with 0x11 and RVALID_1 with 0x22 on successive cycles.
- Fairness: R0 valid continuously, R1 asserts once -> R1 is granted within 1 cycle of asserting, then R0 resumes; never two consecutive R0 grants while R1 is pending.
- Mixed traffic: R1 writes 0x5A5A5A5A to addr 31 while R0 reads addr 31 in the same cycle -> write granted first (pointer favours R1), then R0 read returns 0x5A5A5A5A; RF_WE and RF_RE_A never high together.
- Reset mid-read: assert RST in the cycle after an R0 read grant -> RVALID_0 stays 0; after release, INIT reruns from addr 0.

Source files
------------

// File: rtl/regfile_access_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_access_arbiter
//
// Purpose:
//   Shares the single write port and read port A of a 2^AWIDTH x DWIDTH
//   register file between two requesters (R0, R1). Round-robin arbitration
//   grants at most one command per cycle over a valid/ready handshake. Read
//   data comes back one cycle after the grant, which lines up with the file's
//   registered read. After reset an optional init pass writes zero to every
//   entry before any requester is served.
//
// Ports:
//   CLK, RST                  clock; synchronous active-high reset
//   REQ_VALID_x / REQ_READY_x command handshake per requester (x = 0, 1)
//   REQ_WR_x                  1 = write, 0 = read
//   REQ_ADDR_x, REQ_WDATA_x   command address / write data
//   RVALID_x, RDATA_x         one-cycle read response; RDATA_x is 0 when idle
//   BUSY                      init pass in progress
//   RF_WE, RF_WA, RF_DATAIN   register-file write port
//   RF_RE_A, RF_RA_A          register-file read port A request
//   RF_OUT_A                  register-file read port A data (registered)
// -----------------------------------------------------------------------------
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RESET | first cycle after RST falls; nothing driven
// ST_INIT  | zero-clear pass, one entry per cycle, requesters held off
// ST_RUN   | normal service, round-robin arbitration between R0 and R1

module regfile_access_arbiter #(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 5,
  parameter bit INIT_EN = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,

  input  logic              REQ_VALID_0,
  output logic              REQ_READY_0,
  input  logic              REQ_WR_0,
  input  logic [AWIDTH-1:0] REQ_ADDR_0,
  input  logic [DWIDTH-1:0] REQ_WDATA_0,

  input  logic              REQ_VALID_1,
  output logic              REQ_READY_1,
  input  logic              REQ_WR_1,
  input  logic [AWIDTH-1:0] REQ_ADDR_1,
  input  logic [DWIDTH-1:0] REQ_WDATA_1,

  output logic              RVALID_0,
  output logic [DWIDTH-1:0] RDATA_0,
  output logic              RVALID_1,
  output logic [DWIDTH-1:0] RDATA_1,

  output logic              BUSY,

  output logic              RF_WE,
  output logic [AWIDTH-1:0] RF_WA,
  output logic [DWIDTH-1:0] RF_DATAIN,
  output logic              RF_RE_A,
  output logic [AWIDTH-1:0] RF_RA_A,
  input  logic [DWIDTH-1:0] RF_OUT_A
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_INIT  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [AWIDTH-1:0] CNT_ONE  = {{(AWIDTH-1){1'b0}}, 1'b1};
  localparam logic [AWIDTH-1:0] CNT_LAST = {AWIDTH{1'b1}};

  state_t            state_q;
  state_t            state_d;
  logic [AWIDTH-1:0] init_cnt_q;
  // 1 = R1 received the most recent grant, so R0 wins the next tie.
  logic              last_r1_q;
  logic              rvalid_0_q;
  logic              rvalid_1_q;
  logic              grant_0;
  logic              grant_1;

  // Next state, arbitration and register-file drive. Everything is gated by
  // RST so that the reset-state outputs hold during the reset cycle itself,
  // not only from the following edge.
  always_comb begin
    state_d     = state_q;
    grant_0     = 1'b0;
    grant_1     = 1'b0;
    REQ_READY_0 = 1'b0;
    REQ_READY_1 = 1'b0;
    BUSY        = 1'b0;
    RF_WE       = 1'b0;
    RF_WA       = '0;
    RF_DATAIN   = '0;
    RF_RE_A     = 1'b0;
    RF_RA_A     = '0;

    if (!RST) begin
      case (state_q)
        ST_RESET: begin
          state_d = INIT_EN ? ST_INIT : ST_RUN;
        end

        ST_INIT: begin
          BUSY  = 1'b1;
          RF_WE = 1'b1;
          RF_WA = init_cnt_q;
          if (init_cnt_q == CNT_LAST) begin
            state_d = ST_RUN;
          end
        end

        ST_RUN: begin
          // R0 wins when alone, or on a tie when R1 was granted last.
          // R1 takes every remaining valid cycle, which covers both the
          // R1-alone case and the tie after an R0 grant.
          grant_0 = REQ_VALID_0 && (!REQ_VALID_1 || last_r1_q);
          grant_1 = REQ_VALID_1 && !grant_0;

          REQ_READY_0 = grant_0;
          REQ_READY_1 = grant_1;

          // Only one grant per cycle, so the write port and read port A are
          // never enabled together.
          if (grant_0) begin
            if (REQ_WR_0) begin
              RF_WE     = 1'b1;
              RF_WA     = REQ_ADDR_0;
              RF_DATAIN = REQ_WDATA_0;
            end else begin
              RF_RE_A = 1'b1;
              RF_RA_A = REQ_ADDR_0;
            end
          end else if (grant_1) begin
            if (REQ_WR_1) begin
              RF_WE     = 1'b1;
              RF_WA     = REQ_ADDR_1;
              RF_DATAIN = REQ_WDATA_1;
            end else begin
              RF_RE_A = 1'b1;
              RF_RA_A = REQ_ADDR_1;
            end
          end
        end

        default: begin
          state_d = ST_RESET;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_RESET;
      init_cnt_q <= '0;
      last_r1_q  <= 1'b1;
      rvalid_0_q <= 1'b0;
      rvalid_1_q <= 1'b0;
    end else begin
      state_q <= state_d;

      // Wraps back to zero on the last init write, leaving it clean for
      // the next init pass after a reset.
      if (state_q == ST_INIT) begin
        init_cnt_q <= init_cnt_q + CNT_ONE;
      end else begin
        init_cnt_q <= '0;
      end

      // Pointer moves only on an actual grant; idle cycles keep it.
      if (grant_0) begin
        last_r1_q <= 1'b0;
      end else if (grant_1) begin
        last_r1_q <= 1'b1;
      end

      // The file registers its read, so the response is flagged on the
      // cycle after the read grant.
      rvalid_0_q <= grant_0 && !REQ_WR_0;
      rvalid_1_q <= grant_1 && !REQ_WR_1;
    end
  end

  // A response pending when RST rises is suppressed in that same cycle.
  assign RVALID_0 = rvalid_0_q && !RST;
  assign RVALID_1 = rvalid_1_q && !RST;
  assign RDATA_0  = RVALID_0 ? RF_OUT_A : '0;
  assign RDATA_1  = RVALID_1 ? RF_OUT_A : '0;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_access_arbiter
//
// Self-checking bench for regfile_access_arbiter. Includes a behavioural
// register file (registered read port A) driven by the DUT, a vector table
// for directed traffic, hand-written reset/init sequences, and a randomized
// phase checked against a reference model of the arbitration rules.
// -----------------------------------------------------------------------------

module tb_regfile_access_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 1 << AW;

  logic          CLK;
  logic          RST;
  logic          REQ_VALID_0, REQ_VALID_1;
  logic          REQ_READY_0, REQ_READY_1;
  logic          REQ_WR_0, REQ_WR_1;
  logic [AW-1:0] REQ_ADDR_0, REQ_ADDR_1;
  logic [DW-1:0] REQ_WDATA_0, REQ_WDATA_1;
  logic          RVALID_0, RVALID_1;
  logic [DW-1:0] RDATA_0, RDATA_1;
  logic          BUSY;
  logic          RF_WE;
  logic [AW-1:0] RF_WA;
  logic [DW-1:0] RF_DATAIN;
  logic          RF_RE_A;
  logic [AW-1:0] RF_RA_A;
  logic [DW-1:0] RF_OUT_A;

  regfile_access_arbiter #(
    .DWIDTH (DW),
    .AWIDTH (AW),
    .INIT_EN(1'b1)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ_VALID_0(REQ_VALID_0),
    .REQ_READY_0(REQ_READY_0),
    .REQ_WR_0   (REQ_WR_0),
    .REQ_ADDR_0 (REQ_ADDR_0),
    .REQ_WDATA_0(REQ_WDATA_0),
    .REQ_VALID_1(REQ_VALID_1),
    .REQ_READY_1(REQ_READY_1),
    .REQ_WR_1   (REQ_WR_1),
    .REQ_ADDR_1 (REQ_ADDR_1),
    .REQ_WDATA_1(REQ_WDATA_1),
    .RVALID_0   (RVALID_0),
    .RDATA_0    (RDATA_0),
    .RVALID_1   (RVALID_1),
    .RDATA_1    (RDATA_1),
    .BUSY       (BUSY),
    .RF_WE      (RF_WE),
    .RF_WA      (RF_WA),
    .RF_DATAIN  (RF_DATAIN),
    .RF_RE_A    (RF_RE_A),
    .RF_RA_A    (RF_RA_A),
    .RF_OUT_A   (RF_OUT_A)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural register file. Starts filled with non-zero garbage so the
  // init pass has something to clear.
  logic [DW-1:0] rf_mem [DEPTH];
  logic          rf_scramble;

  always @(posedge CLK) begin
    if (rf_scramble) begin
      for (int i = 0; i < DEPTH; i++) rf_mem[i] <= 32'hA5A50000 + 32'(i) + 32'd1;
    end else if (RF_WE) begin
      rf_mem[RF_WA] <= RF_DATAIN;
    end
    if (RF_RE_A) RF_OUT_A <= rf_mem[RF_RA_A];
  end

  int total;
  int bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  // Entered just after a posedge. Waits for BUSY, then checks each init
  // write. abort_after > 0 returns after that many init cycles.
  task automatic run_init(input int abort_after);
    int n;
    int guard;
    n = 0;
    guard = 0;
    sample();
    while (!BUSY && guard < 8) begin
      step();
      sample();
      guard++;
    end
    check("init_busy_rise", 32'(BUSY), 32'd1);
    while (BUSY && n < 40) begin
      check("init_we", 32'(RF_WE), 32'd1);
      check("init_wa", 32'(RF_WA), 32'(n));
      check("init_din", RF_DATAIN, 32'd0);
      check("init_re", 32'(RF_RE_A), 32'd0);
      check("init_rdy0", 32'(REQ_READY_0), 32'd0);
      check("init_rdy1", 32'(REQ_READY_1), 32'd0);
      n++;
      if (abort_after != 0 && n == abort_after) return;
      step();
      sample();
    end
    check("init_len", 32'(n), 32'(DEPTH));
  endtask

  typedef struct {
    logic          v0, v1, wr0, wr1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          rdy0, rdy1, rv0, rv1;
    logic [DW-1:0] rdata;
  } vec_t;

  function automatic vec_t mk(input logic v0, input logic wr0, input logic [AW-1:0] a0,
                              input logic [DW-1:0] d0, input logic v1, input logic wr1,
                              input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic rdy0, input logic rdy1, input logic rv0,
                              input logic rv1, input logic [DW-1:0] rdata);
    vec_t v;
    v.v0 = v0; v.wr0 = wr0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.wr1 = wr1; v.a1 = a1; v.d1 = d1;
    v.rdy0 = rdy0; v.rdy1 = rdy1; v.rv0 = rv0; v.rv1 = rv1; v.rdata = rdata;
    return v;
  endfunction

  vec_t tbl [15];

  // Reference model state for the random phase.
  logic [DW-1:0] ref_mem [DEPTH];
  logic          ref_last_r1;
  logic          pv [2];
  logic          pwr [2];
  logic [AW-1:0] pa [2];
  logic [DW-1:0] pd [2];
  logic          exp_rv [2];
  logic [DW-1:0] exp_rd;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          e_we, e_re;
    logic [AW-1:0] e_wa, e_ra;
    logic [DW-1:0] e_din;
    int            w;

    total = 0;
    bad = 0;

    // Directed vectors; the pointer starts as "R0 granted last" because the
    // table follows the post-init R0 read of addr 7.
    tbl[0]  = mk(1'b1, 1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 1'b0, 5'd0,  32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[1]  = mk(1'b1, 1'b0, 5'd3,  32'd0,        1'b0, 1'b0, 5'd0,  32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[2]  = mk(1'b1, 1'b1, 5'd2,  32'h22,       1'b1, 1'b1, 5'd1,  32'h11,       1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF);
    tbl[3]  = mk(1'b1, 1'b1, 5'd2,  32'h22,       1'b0, 1'b0, 5'd0,  32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[4]  = mk(1'b1, 1'b0, 5'd1,  32'd0,        1'b1, 1'b0, 5'd2,  32'd0,        1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    tbl[5]  = mk(1'b1, 1'b0, 5'd1,  32'd0,        1'b1, 1'b0, 5'd2,  32'd0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h22);
    tbl[6]  = mk(1'b1, 1'b0, 5'd1,  32'd0,        1'b1, 1'b0, 5'd2,  32'd0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h11);
    tbl[7]  = mk(1'b1, 1'b0, 5'd1,  32'd0,        1'b1, 1'b0, 5'd2,  32'd0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h22);
    tbl[8]  = mk(1'b0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h11);
    tbl[9]  = mk(1'b1, 1'b0, 5'd1,  32'd0,        1'b0, 1'b0, 5'd0,  32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[10] = mk(1'b1, 1'b0, 5'd1,  32'd0,        1'b1, 1'b0, 5'd2,  32'd0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h11);
    tbl[11] = mk(1'b1, 1'b0, 5'd1,  32'd0,        1'b0, 1'b0, 5'd0,  32'd0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h22);
    tbl[12] = mk(1'b1, 1'b0, 5'd31, 32'd0,        1'b1, 1'b1, 5'd31, 32'h5A5A5A5A, 1'b0, 1'b1, 1'b1, 1'b0, 32'h11);
    tbl[13] = mk(1'b1, 1'b0, 5'd31, 32'd0,        1'b0, 1'b0, 5'd0,  32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[14] = mk(1'b0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h5A5A5A5A);

    // ---- reset state, with R0 asking for addr 7 throughout ----
    rf_scramble = 1'b1;
    RST = 1'b1;
    REQ_VALID_0 = 1'b1; REQ_WR_0 = 1'b0; REQ_ADDR_0 = 5'd7; REQ_WDATA_0 = '0;
    REQ_VALID_1 = 1'b1; REQ_WR_1 = 1'b1; REQ_ADDR_1 = 5'd4; REQ_WDATA_1 = 32'h1234;
    step();
    rf_scramble = 1'b0;
    sample();
    check("rst_rdy0", 32'(REQ_READY_0), 32'd0);
    check("rst_rdy1", 32'(REQ_READY_1), 32'd0);
    check("rst_rv0", 32'(RVALID_0), 32'd0);
    check("rst_rv1", 32'(RVALID_1), 32'd0);
    check("rst_we", 32'(RF_WE), 32'd0);
    check("rst_re", 32'(RF_RE_A), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    step();
    RST = 1'b0;
    REQ_VALID_1 = 1'b0;

    // ---- init pass, then the held R0 read of addr 7 ----
    run_init(0);
    check("post_init_rdy0", 32'(REQ_READY_0), 32'd1);
    check("post_init_re", 32'(RF_RE_A), 32'd1);
    check("post_init_ra", 32'(RF_RA_A), 32'd7);
    step();
    REQ_VALID_0 = 1'b0;
    sample();
    check("addr7_rv0", 32'(RVALID_0), 32'd1);
    check("addr7_rdata0", RDATA_0, 32'd0);

    // ---- directed vector table ----
    for (int i = 0; i < 15; i++) begin
      step();
      REQ_VALID_0 = tbl[i].v0; REQ_WR_0 = tbl[i].wr0; REQ_ADDR_0 = tbl[i].a0; REQ_WDATA_0 = tbl[i].d0;
      REQ_VALID_1 = tbl[i].v1; REQ_WR_1 = tbl[i].wr1; REQ_ADDR_1 = tbl[i].a1; REQ_WDATA_1 = tbl[i].d1;
      sample();
      e_we  = (tbl[i].rdy0 && tbl[i].wr0) || (tbl[i].rdy1 && tbl[i].wr1);
      e_re  = (tbl[i].rdy0 && !tbl[i].wr0) || (tbl[i].rdy1 && !tbl[i].wr1);
      e_wa  = !e_we ? '0 : (tbl[i].rdy0 ? tbl[i].a0 : tbl[i].a1);
      e_ra  = !e_re ? '0 : (tbl[i].rdy0 ? tbl[i].a0 : tbl[i].a1);
      e_din = !e_we ? '0 : (tbl[i].rdy0 ? tbl[i].d0 : tbl[i].d1);
      check($sformatf("vec%0d_rdy0", i), 32'(REQ_READY_0), 32'(tbl[i].rdy0));
      check($sformatf("vec%0d_rdy1", i), 32'(REQ_READY_1), 32'(tbl[i].rdy1));
      check($sformatf("vec%0d_we", i), 32'(RF_WE), 32'(e_we));
      check($sformatf("vec%0d_re", i), 32'(RF_RE_A), 32'(e_re));
      check($sformatf("vec%0d_wa", i), 32'(RF_WA), 32'(e_wa));
      check($sformatf("vec%0d_ra", i), 32'(RF_RA_A), 32'(e_ra));
      check($sformatf("vec%0d_din", i), RF_DATAIN, e_din);
      check($sformatf("vec%0d_rv0", i), 32'(RVALID_0), 32'(tbl[i].rv0));
      check($sformatf("vec%0d_rv1", i), 32'(RVALID_1), 32'(tbl[i].rv1));
      check($sformatf("vec%0d_rdata0", i), RDATA_0, tbl[i].rv0 ? tbl[i].rdata : 32'd0);
      check($sformatf("vec%0d_rdata1", i), RDATA_1, tbl[i].rv1 ? tbl[i].rdata : 32'd0);
    end

    // ---- reset in the cycle after a read grant ----
    step();
    REQ_VALID_0 = 1'b1; REQ_WR_0 = 1'b0; REQ_ADDR_0 = 5'd3;
    sample();
    check("midrd_grant0", 32'(REQ_READY_0), 32'd1);
    step();
    RST = 1'b1;
    REQ_VALID_0 = 1'b0;
    sample();
    check("midrd_rv0", 32'(RVALID_0), 32'd0);
    check("midrd_rdata0", RDATA_0, 32'd0);
    check("midrd_we", 32'(RF_WE), 32'd0);
    check("midrd_re", 32'(RF_RE_A), 32'd0);
    step();
    RST = 1'b0;
    sample();
    check("midrd_rv0_after", 32'(RVALID_0), 32'd0);

    // ---- partial init, reset again, then a full init from addr 0 ----
    run_init(10);
    step();
    RST = 1'b1;
    sample();
    check("midinit_busy", 32'(BUSY), 32'd0);
    check("midinit_we", 32'(RF_WE), 32'd0);
    step();
    RST = 1'b0;
    REQ_VALID_1 = 1'b1; REQ_WR_1 = 1'b0; REQ_ADDR_1 = 5'd3;
    run_init(0);
    check("reinit_rdy1", 32'(REQ_READY_1), 32'd1);
    check("reinit_rdy0", 32'(REQ_READY_0), 32'd0);
    check("reinit_ra", 32'(RF_RA_A), 32'd3);
    step();
    REQ_VALID_1 = 1'b0;
    sample();
    check("reinit_rv1", 32'(RVALID_1), 32'd1);
    check("reinit_rdata1", RDATA_1, 32'd0);
    check("reinit_rv0", 32'(RVALID_0), 32'd0);

    // ---- randomized traffic against the reference model ----
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_last_r1 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      pv[k] = 1'b0; pwr[k] = 1'b0; pa[k] = '0; pd[k] = '0; exp_rv[k] = 1'b0;
    end
    exp_rd = '0;

    for (int c = 0; c < 600; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        if (!pv[k] && $urandom_range(0, 99) < 55) begin
          pv[k]  = 1'b1;
          pwr[k] = 1'($urandom_range(0, 1));
          pa[k]  = ($urandom_range(0, 4) == 4) ? 5'd31 : 5'($urandom_range(0, 3));
          pd[k]  = $urandom;
        end
      end
      REQ_VALID_0 = pv[0]; REQ_WR_0 = pwr[0]; REQ_ADDR_0 = pa[0]; REQ_WDATA_0 = pd[0];
      REQ_VALID_1 = pv[1]; REQ_WR_1 = pwr[1]; REQ_ADDR_1 = pa[1]; REQ_WDATA_1 = pd[1];
      sample();

      check("rnd_rv0", 32'(RVALID_0), 32'(exp_rv[0]));
      check("rnd_rv1", 32'(RVALID_1), 32'(exp_rv[1]));
      check("rnd_rdata0", RDATA_0, exp_rv[0] ? exp_rd : 32'd0);
      check("rnd_rdata1", RDATA_1, exp_rv[1] ? exp_rd : 32'd0);

      // Winner: the sole requester, or on a tie whoever was not served last.
      if (pv[0] && pv[1]) w = ref_last_r1 ? 0 : 1;
      else if (pv[0])     w = 0;
      else if (pv[1])     w = 1;
      else                w = -1;

      check("rnd_rdy0", 32'(REQ_READY_0), 32'(w == 0));
      check("rnd_rdy1", 32'(REQ_READY_1), 32'(w == 1));
      check("rnd_excl", 32'(RF_WE && RF_RE_A), 32'd0);

      exp_rv[0] = 1'b0;
      exp_rv[1] = 1'b0;
      if (w >= 0) begin
        check("rnd_we", 32'(RF_WE), 32'(pwr[w]));
        check("rnd_re", 32'(RF_RE_A), 32'(!pwr[w]));
        if (pwr[w]) begin
          check("rnd_wa", 32'(RF_WA), 32'(pa[w]));
          check("rnd_din", RF_DATAIN, pd[w]);
          ref_mem[pa[w]] = pd[w];
        end else begin
          check("rnd_ra", 32'(RF_RA_A), 32'(pa[w]));
          exp_rv[w] = 1'b1;
          exp_rd = ref_mem[pa[w]];
        end
        ref_last_r1 = (w == 1);
        pv[w] = 1'b0;
      end else begin
        check("rnd_idle_we", 32'(RF_WE), 32'd0);
        check("rnd_idle_re", 32'(RF_RE_A), 32'd0);
      end
    end

    step();
    REQ_VALID_0 = 1'b0;
    REQ_VALID_1 = 1'b0;
    sample();
    check("final_rv0", 32'(RVALID_0), 32'(exp_rv[0]));
    check("final_rv1", 32'(RVALID_1), 32'(exp_rv[1]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
